blink_leds: RTL and testbench
=============================

Name: blink_leds

Overview:
- Board-level LED pattern generator for the icestick: four user LEDs (LED1..LED4) show a selectable animated pattern; LED5 is a heartbeat.
- Four switch inputs select the pattern mode, blink speed, pause and inversion.
- Switches are asynchronous to clk and are synchronised inside the block.
- Sits directly under the top-level pin wrapper.

Parameters:
- DIV, 6000000, clk cycles per pattern tick at normal speed (0.5 s at 12 MHz); must be >= 4.
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronised cycles required before a switch change is accepted (only with DEBOUNCE_EN).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- SW1  input  1  mode-advance switch; rising edge selects next mode
- SW2  input  1  speed switch; rising edge toggles normal/fast
- SW3  input  1  pause, level-sensitive; 1 freezes pattern
- SW4  input  1  invert, level-sensitive; 1 inverts LED1..LED4
- LED1 output 1  pattern bit 0
- LED2 output 1  pattern bit 1
- LED3 output 1  pattern bit 2
- LED4 output 1  pattern bit 3
- LED5 output 1  heartbeat

Behaviour:
- Reset (async, rst=1), all held while asserted:
  - prescaler=0, mode=0, speed=normal, pattern=4'b0000, direction=up, heartbeat=0, synchronisers=0, edge-history=0.
  - All LEDs 0.
- Switch path:
  - Each SWn passes through a 2-flop synchroniser (sN); a history flop pN holds the previous sN.
  - Rising edge: rN = sN & ~pN.
  - Latency: a switch high at clk edge 1 gives sN=1 after edge 2. rN is high for exactly one cycle between edges 2 and 3. State changes caused by rN occur at edge 3.
- Prescaler:
  - Counts 0..T-1 and wraps to 0. T=DIV (normal) or DIV/4 (fast, integer division).
  - tick = 1 for the single cycle where count==T-1.
  - Cleared to 0 on r2 (speed toggle) and on r1 (mode change); no tick is produced in that cycle.
- Heartbeat: LED5 toggles on every tick. It runs during pause and is unaffected by SW4.
- Pattern register P[3:0] advances on tick when s3==0. When s3==1, P holds; prescaler and heartbeat keep running.
- Modes (2-bit, r1 increments mod 4, 3 wraps to 0):
  - 0 flash: P toggles 0000 <-> 1111.
  - 1 chase: one-hot rotate left 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - 2 count: P = P+1 mod 16.
  - 3 bounce: one-hot shift left to 1000, then right to 0001, repeat (0001,0010,0100,1000,0100,0010,0001,...). Direction flips at the ends.
- On r1, P loads the new mode's start value in the same edge as the mode update; direction resets to up.
  - Start values: mode0 0000, mode1 0001, mode2 0000, mode3 0001.
- Simultaneous r1 and tick: r1 wins (load start value, clear prescaler).
- Simultaneous r1 and r2: both take effect; prescaler cleared.
- Outputs:
  - LEDn = P[n-1] ^ s4, combinational from registers, so no extra latency beyond the synchroniser.
  - r1 or r2 while paused still applies (mode change reloads P even when paused).
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined: after the synchroniser, each switch has a counter. The debounced level dN updates only after sN differs from dN for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Edge detect and the SW3/SW4 levels use dN. Latency becomes 2 + DEBOUNCE_CYCLES (+1 for edges).
- Undefined: dN = sN; no counters are synthesised.

Test Plan:
- Reset: rst=1, switches 0 -> LED1..5=0. Release rst with DIV=8 -> LED5 toggles every 8 cycles; LED1..4 show 1111, 0000, 1111 on successive ticks.
- Mode advance: SW1 high for 2 cycles -> mode=1 and P=0001 exactly at the 3rd edge after SW1 sampled high. Next ticks give 0010, 0100, 1000, 0001. Three more SW1 pulses -> mode 2, 3, then 0.
- Bounce mode (mode3, DIV=8) -> LEDs over 7 ticks: 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Speed: SW2 pulse with DIV=8 -> prescaler cleared, then ticks every 2 cycles. Second SW2 pulse -> back to every 8 cycles.
- Pause/invert: in mode 2 at P=0101, SW3=1 -> P stays 0101 over 3 ticks while LED5 keeps toggling. SW4=1 -> LEDs read 1010 two edges later. SW3=0 -> counting resumes at 0110.
- DEBOUNCE_EN with DEBOUNCE_CYCLES=4: SW1 high for 3 cycles -> no mode change. SW1 high for 10 cycles -> exactly one mode advance.

Source files
------------

// File: rtl/blink_leds.sv
// blink_leds: icestick LED pattern generator with synchronised switch controls and a heartbeat.
// Define DEBOUNCE_EN to add a per-switch debounce counter after the synchroniser.
module blink_leds #(
    parameter int DIV             = 6000000,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic SW1,
    input  logic SW2,
    input  logic SW3,
    input  logic SW4,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5
);

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    localparam int              CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST_NORMAL = CW'(DIV - 1);
    localparam logic [CW-1:0]   LAST_FAST   = CW'(DIV / 4 - 1);

    logic [3:0] sw;
    logic [3:0] meta;
    logic [3:0] sync;
    logic [3:0] lvl;
    logic [3:0] prev;
    logic [3:0] rise;
    logic       r1;
    logic       r2;
    logic       pause;
    logic       invert;

    assign sw = {SW4, SW3, SW2, SW1};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= sw;
            sync <= meta;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic [DBW-1:0] db_cnt [4];

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= sync[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end
`else
    assign lvl = sync;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= lvl;
    end

    assign rise   = lvl & ~prev;
    assign r1     = rise[0];
    assign r2     = rise[1];
    assign pause  = lvl[2];
    assign invert = lvl[3];

    // Prescaler: a mode or speed change restarts the tick period and suppresses that tick.
    logic [CW-1:0] count;
    logic          fast;
    logic          at_last;
    logic          tick;

    assign at_last = (count == (fast ? LAST_FAST : LAST_NORMAL));
    assign tick    = at_last & ~r1 & ~r2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      count <= '0;
        else if (r1 || r2 || at_last) count <= '0;
        else                          count <= count + CW'(1);
    end

    // Pattern state: register / next-state / output processes.
    mode_t      mode, mode_nxt;
    logic [3:0] pat, pat_nxt;
    logic       dir_up, dir_up_nxt;
    logic       fast_nxt;
    logic       heart, heart_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode   <= MODE_FLASH;
            pat    <= 4'b0000;
            dir_up <= 1'b1;
            fast   <= 1'b0;
            heart  <= 1'b0;
        end else begin
            mode   <= mode_nxt;
            pat    <= pat_nxt;
            dir_up <= dir_up_nxt;
            fast   <= fast_nxt;
            heart  <= heart_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        mode_nxt   = mode;
        pat_nxt    = pat;
        dir_up_nxt = dir_up;
        fast_nxt   = fast ^ r2;
        heart_nxt  = heart ^ tick;
        if (r1) begin
            mode_nxt   = mode_t'(mode + 2'd1);
            dir_up_nxt = 1'b1;
            pat_nxt    = (mode_nxt == MODE_CHASE || mode_nxt == MODE_BOUNCE) ? 4'b0001 : 4'b0000;
        end else if (tick && !pause) begin
            case (mode)
                MODE_FLASH: pat_nxt = ~pat;
                MODE_CHASE: pat_nxt = {pat[2:0], pat[3]};
                MODE_COUNT: pat_nxt = pat + 4'd1;
                default: begin
                    if (dir_up) begin
                        if (pat[3]) begin
                            pat_nxt    = 4'b0100;
                            dir_up_nxt = 1'b0;
                        end else begin
                            pat_nxt = pat << 1;
                        end
                    end else if (pat[0]) begin
                        pat_nxt    = 4'b0010;
                        dir_up_nxt = 1'b1;
                    end else begin
                        pat_nxt = pat >> 1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        {LED4, LED3, LED2, LED1} = pat ^ {4{invert}};
        LED5                     = heart;
    end

endmodule

// File: tb/tb_blink_leds.sv
// tb_blink_leds: table-driven and randomised checks of blink_leds against a pattern-index model.
module tb_blink_leds;

    localparam int DIV = 8;
    localparam int DBC = 4;

    logic clk = 1'b0;
    logic rst;
    logic SW1, SW2, SW3, SW4;
    logic LED1, LED2, LED3, LED4, LED5;

    always #5 clk = ~clk;

    blink_leds #(.DIV(DIV), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk (clk),
        .rst (rst),
        .SW1 (SW1),
        .SW2 (SW2),
        .SW3 (SW3),
        .SW4 (SW4),
        .LED1(LED1),
        .LED2(LED2),
        .LED3(LED3),
        .LED4(LED4),
        .LED5(LED5)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] leds();
        return {LED5, LED4, LED3, LED2, LED1};
    endfunction

    function automatic logic [3:0] pat_leds();
        return {LED4, LED3, LED2, LED1};
    endfunction

    // Reference model: pattern = sequence[mode][step index]; switch path as a sampled delay line.
    logic [3:0] bounce_tbl [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    int         m_mode, m_k, m_phase;
    bit         m_fast, m_hb;
    logic [3:0] m_meta, m_sync, m_lvl, m_prev;
    logic [3:0] s_hist[$];

    function automatic logic [3:0] model_pat(input int mode, input int k);
        case (mode)
            0:       return (k % 2 == 1) ? 4'b1111 : 4'b0000;
            1:       return 4'b0001 << (k % 4);
            2:       return 4'(k % 16);
            default: return bounce_tbl[k % 6];
        endcase
    endfunction

    function automatic logic [4:0] exp_leds();
        return {m_hb, model_pat(m_mode, m_k) ^ {4{m_lvl[3]}}};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_phase = 0; m_fast = 0; m_hb = 0;
        m_meta = '0; m_sync = '0; m_lvl = '0; m_prev = '0;
        s_hist.delete();
    endtask

    task automatic model_edge(input logic [3:0] sw);
        logic [3:0] r;
        int         period;
        bit         tick;
        r      = m_lvl & ~m_prev;
        period = m_fast ? DIV / 4 : DIV;
        tick   = (m_phase == period - 1) && !r[0] && !r[1];
        if (r[0] || r[1] || m_phase == period - 1) m_phase = 0;
        else m_phase++;
        if (tick) m_hb = !m_hb;
        if (r[1]) m_fast = !m_fast;
        if (r[0]) begin
            m_mode = (m_mode + 1) % 4;
            m_k    = 0;
        end else if (tick && !m_lvl[2]) begin
            m_k++;
        end
        m_prev = m_lvl;
`ifdef DEBOUNCE_EN
        s_hist.push_front(m_sync);
        if (s_hist.size() > DBC) void'(s_hist.pop_back());
        if (s_hist.size() == DBC) begin
            for (int b = 0; b < 4; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                foreach (s_hist[j]) if (s_hist[j][b] == m_lvl[b]) all_diff = 1'b0;
                if (all_diff) m_lvl[b] = m_sync[b];
            end
        end
        m_sync = m_meta;
`else
        m_lvl = m_meta;
`endif
        m_meta = sw;
    endtask

    // One clock: drive switches, let the edge happen, advance the model, compare.
    task automatic cycle(input logic [3:0] sw);
        {SW4, SW3, SW2, SW1} = sw;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(sw);
        #1;
        check("model", 32'(leds()), 32'(exp_leds()));
    endtask

    task automatic run(input logic [3:0] sw, input int n);
        for (int i = 0; i < n; i++) cycle(sw);
    endtask

    task automatic pulse(input logic [3:0] sw);
        cycle(sw);
        cycle(sw);
        cycle(4'b0000);
    endtask

    task automatic measure_period(output int period);
        int   toggles;
        int   last_t;
        logic hb;
        toggles = 0;
        last_t  = 0;
        period  = -1;
        hb      = LED5;
        for (int i = 1; i <= 40 && toggles < 3; i++) begin
            cycle(4'b0000);
            if (LED5 !== hb) begin
                hb = LED5;
                toggles++;
                if (toggles == 3) period = i - last_t;
                last_t = i;
            end
        end
    endtask

    typedef struct {
        logic [3:0] sw;
        int         n;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int         period;
        bit         hb_at_t;
        logic [3:0] sw;
        logic [3:0] seq4 [4];
        logic [3:0] seq7 [7];

        model_reset();
        rst = 1'b1;
        {SW4, SW3, SW2, SW1} = 4'b0000;
        run(4'b0000, 3);
        check("reset_leds", 32'(leds()), 32'h0);
        rst = 1'b0;

`ifndef DEBOUNCE_EN
        // {switches, cycles, expected {LED5..LED1} after the last cycle}
        vecs[0] = '{4'b0000, 7, 5'b00000};
        vecs[1] = '{4'b0000, 1, 5'b11111};
        vecs[2] = '{4'b0000, 7, 5'b11111};
        vecs[3] = '{4'b0000, 1, 5'b00000};
        vecs[4] = '{4'b0000, 8, 5'b11111};
        vecs[5] = '{4'b1000, 2, 5'b10000};
        vecs[6] = '{4'b1000, 6, 5'b01111};
        vecs[7] = '{4'b0000, 2, 5'b00000};
        for (int v = 0; v < 8; v++) begin
            run(vecs[v].sw, vecs[v].n);
            check($sformatf("vec%0d", v), 32'(leds()), 32'(vecs[v].exp));
        end

        // Mode 1 chase: loaded on the third edge after SW1 is first sampled.
        pulse(4'b0001);
        check("mode1_load", 32'(pat_leds()), 32'h1);
        seq4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            run(4'b0000, 8);
            check($sformatf("chase%0d", i), 32'(pat_leds()), 32'(seq4[i]));
        end

        // Mode 2 count, then pause and invert.
        pulse(4'b0001);
        check("mode2_load", 32'(pat_leds()), 32'h0);
        run(4'b0000, 40);
        check("count_0101", 32'(pat_leds()), 32'h5);
        hb_at_t = m_hb;
        run(4'b0100, 24);
        check("pause_hold", 32'(leds()), 32'({~hb_at_t, 4'b0101}));
        cycle(4'b1100);
        check("invert_early", 32'(pat_leds()), 32'h5);
        cycle(4'b1100);
        check("invert_on", 32'(pat_leds()), 32'hA);
        run(4'b0000, 2);
        for (int i = 0; i < 10 && pat_leds() == 4'b0101; i++) cycle(4'b0000);
        check("resume_0110", 32'(pat_leds()), 32'h6);

        // Mode 3 bounce.
        pulse(4'b0001);
        check("mode3_load", 32'(pat_leds()), 32'h1);
        seq7 = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        for (int i = 0; i < 7; i++) begin
            run(4'b0000, 8);
            check($sformatf("bounce%0d", i), 32'(pat_leds()), 32'(seq7[i]));
        end
        pulse(4'b0001);
        check("mode0_wrap", 32'(pat_leds()), 32'h0);

        // Speed toggle: heartbeat period 2, then back to 8.
        pulse(4'b0010);
        measure_period(period);
        check("fast_period", 32'(period), 32'd2);
        pulse(4'b0010);
        measure_period(period);
        check("normal_period", 32'(period), 32'd8);
`else
        // Short SW1 pulse is filtered; a long one advances exactly once.
        run(4'b0001, 3);
        run(4'b0000, 20);
        check("db_short", 32'(pat_leds() == 4'b0000 || pat_leds() == 4'b1111), 32'd1);
        run(4'b0001, 7);
        check("db_long_load", 32'(pat_leds()), 32'h1);
        run(4'b0001, 3);
        run(4'b0000, 5);
        check("db_once", 32'(pat_leds()), 32'h2);
        run(4'b0000, 20);
`endif

        // Randomised switch activity with a mid-run reset.
        sw = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(39) == 0) sw[0] = ~sw[0];
            if ($urandom_range(59) == 0) sw[1] = ~sw[1];
            if ($urandom_range(29) == 0) sw[2] = ~sw[2];
            if ($urandom_range(29) == 0) sw[3] = ~sw[3];
            if (i == 700) begin
                rst = 1'b1;
                #1;
                check("async_reset", 32'(leds()), 32'h0);
                run(sw, 2);
                rst = 1'b0;
            end
            cycle(sw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
